// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source. Turns timing-generator coordinates into 24-bit RGB through a fixed
// 2-stage pipeline, with sync/blank delayed to match.
module vga_pattern_gen #(
   parameter int WIDTH      = 12,
   parameter int H_ACTIVE   = 1920,
   parameter int V_ACTIVE   = 1080,
   parameter int BOX_SIZE   = 64,
   parameter int BOX_STEP   = 4,
   parameter int RAMP_SHIFT = 3,
   parameter int CHK_SHIFT  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] hdata,
   input  logic [WIDTH-1:0] vdata,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             blank,
   input  logic [2:0]       mode,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             blank_o,
   output logic             frame_start,
   output logic [15:0]      frame_cnt
);

   typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;
   typedef enum logic [2:0] {
      PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_GRID, PAT_BOX, PAT_WHITE, PAT_BLACK6, PAT_BLACK7
   } pat_t;

   localparam logic [WIDTH-1:0] XM    = WIDTH'(H_ACTIVE - BOX_SIZE);
   localparam logic [WIDTH-1:0] YM    = WIDTH'(V_ACTIVE - BOX_SIZE);
   localparam logic [WIDTH-1:0] STEP  = WIDTH'(BOX_STEP);
   localparam logic [WIDTH:0]   SIZE  = (WIDTH+1)'(BOX_SIZE);
   localparam logic [WIDTH-1:0] H_END = WIDTH'(H_ACTIVE - 1);
   localparam logic [WIDTH-1:0] V_END = WIDTH'(V_ACTIVE - 1);

   // Returns {direction, position} for one frame of bounce along an axis clamped to [0, lim].
   function automatic logic [WIDTH:0] f_bounce(input logic [WIDTH-1:0] pos, input dir_t dir,
                                               input logic [WIDTH-1:0] lim);
      logic [WIDTH:0] sum;
      sum = {1'b0, pos} + {1'b0, STEP};
      if (dir == DIR_POS) begin
         if (sum >= {1'b0, lim}) return {1'b1, lim};
         return {1'b0, sum[WIDTH-1:0]};
      end
      if (pos <= STEP) return {1'b0, WIDTH'(0)};
      return {1'b1, pos - STEP};
   endfunction

   pat_t             r_mode;
   logic [WIDTH-1:0] r_bx, r_by;
   dir_t             r_dx, r_dy;
   logic             r_synced;
   logic [15:0]      r_frame_cnt;

   logic [WIDTH-1:0] r1_h, r1_v;
   logic             r1_hs, r1_vs, r1_blank, r1_fs;
   logic [2:0]       r1_bar;

   logic             w_fs;
   logic [2:0]       w_bar;
   logic [WIDTH:0]   w_bx_upd, w_by_upd;
   logic [2:0]       w_code;
   logic [7:0]       w_ramp;
   logic             w_grid, w_in_box;
   logic [23:0]      w_rgb;

   assign w_fs     = (hdata == '0) && (vdata == '0) && !blank;
   assign w_bx_upd = f_bounce(r_bx, r_dx, XM);
   assign w_by_upd = f_bounce(r_by, r_dy, YM);

   // Bar index = number of H_ACTIVE*k/8 thresholds already reached.
   always_comb begin
      w_bar = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (hdata >= WIDTH'(H_ACTIVE * k / 8)) w_bar = w_bar + 3'd1;
      end
   end

   // Stage 1: capture inputs; frame-start also latches mode and advances the box.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_h        <= '0;
         r1_v        <= '0;
         r1_hs       <= 1'b0;
         r1_vs       <= 1'b0;
         r1_blank    <= 1'b1;
         r1_fs       <= 1'b0;
         r1_bar      <= '0;
         r_mode      <= PAT_BARS;
         r_bx        <= '0;
         r_by        <= '0;
         r_dx        <= DIR_POS;
         r_dy        <= DIR_POS;
         r_synced    <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r1_h     <= hdata;
         r1_v     <= vdata;
         r1_hs    <= hsync;
         r1_vs    <= vsync;
         r1_blank <= blank | ~(r_synced | w_fs);
         r1_fs    <= w_fs;
         r1_bar   <= w_bar;
         if (w_fs) begin
            r_mode      <= pat_t'(mode);
            r_bx        <= w_bx_upd[WIDTH-1:0];
            r_dx        <= dir_t'(w_bx_upd[WIDTH]);
            r_by        <= w_by_upd[WIDTH-1:0];
            r_dy        <= dir_t'(w_by_upd[WIDTH]);
            r_synced    <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign w_ramp   = 8'(r1_h >> RAMP_SHIFT);
   assign w_grid   = (r1_h[5:0] == 6'd0) || (r1_v[5:0] == 6'd0) || (r1_h == H_END) || (r1_v == V_END);
   assign w_in_box = (r1_h >= r_bx) && ({1'b0, r1_h} < ({1'b0, r_bx} + SIZE)) &&
                     (r1_v >= r_by) && ({1'b0, r1_v} < ({1'b0, r_by} + SIZE));

   always_comb begin
      case (r1_bar)
         3'd0:    w_code = 3'b111;
         3'd1:    w_code = 3'b110;
         3'd2:    w_code = 3'b011;
         3'd3:    w_code = 3'b010;
         3'd4:    w_code = 3'b101;
         3'd5:    w_code = 3'b100;
         3'd6:    w_code = 3'b001;
         default: w_code = 3'b000;
      endcase
   end

   always_comb begin
      w_rgb = '0;
      case (r_mode)
         PAT_BARS:  w_rgb = {{8{w_code[2]}}, {8{w_code[1]}}, {8{w_code[0]}}};
         PAT_RAMP:  w_rgb = {w_ramp, w_ramp, w_ramp};
         PAT_CHECK: w_rgb = {24{r1_h[CHK_SHIFT] ^ r1_v[CHK_SHIFT]}};
         PAT_GRID:  w_rgb = {24{w_grid}};
         PAT_BOX:   w_rgb = w_in_box ? 24'hFFFFFF : 24'h0000FF;
         PAT_WHITE: w_rgb = '1;
         default:   w_rgb = '0;
      endcase
   end

   // Stage 2: colour select with blanking, sync/blank/frame-start delayed to match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         hsync_o     <= 1'b0;
         vsync_o     <= 1'b0;
         blank_o     <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         {red, green, blue} <= r1_blank ? 24'd0 : w_rgb;
         hsync_o     <= r1_hs;
         vsync_o     <= r1_vs;
         blank_o     <= r1_blank;
         frame_start <= r1_fs;
      end
   end

   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: frame-level reference model compared every cycle, plus
// hand-computed pixel/counter checks.
module tb_vga_pattern_gen;

   localparam int WIDTH = 12, H_ACTIVE = 1920, V_ACTIVE = 1080, BOX_SIZE = 64, BOX_STEP = 4;
   localparam logic [23:0] W = 24'hFFFFFF, K = 24'h000000, B = 24'h0000FF;
   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] hdata = '0, vdata = '0;
   logic             hsync = 1'b0, vsync = 1'b0, blank = 1'b1;
   logic [2:0]       mode = 3'd0;
   logic [7:0]       red, green, blue;
   logic             hsync_o, vsync_o, blank_o, frame_start;
   logic [15:0]      frame_cnt;

   int n_vec = 0, n_err = 0;

   vga_pattern_gen #(.WIDTH(WIDTH), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
                     .BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP), .RAMP_SHIFT(3), .CHK_SHIFT(5)) dut (
      .clk(clk), .rst_n(rst_n), .hdata(hdata), .vdata(vdata), .hsync(hsync), .vsync(vsync),
      .blank(blank), .mode(mode), .red(red), .green(green), .blue(blue), .hsync_o(hsync_o),
      .vsync_o(vsync_o), .blank_o(blank_o), .frame_start(frame_start), .frame_cnt(frame_cnt));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
      end
   endtask

   // Triangle wave: position after travelling distance t back and forth over [0, m].
   function automatic int bounce(input int t, input int m);
      int r;
      r = t % (2 * m);
      return (r <= m) ? r : 2 * m - r;
   endfunction

   function automatic logic [23:0] model_rgb(input logic [2:0] m, input int h, input int v, input int n);
      int bx, by;
      logic [7:0] g;
      bx = bounce(n * BOX_STEP, H_ACTIVE - BOX_SIZE);
      by = bounce(n * BOX_STEP, V_ACTIVE - BOX_SIZE);
      case (m)
         3'd0: return BARS[h * 8 / H_ACTIVE];
         3'd1: begin g = 8'((h / 8) % 256); return {g, g, g}; end
         3'd2: return (((h / 32) + (v / 32)) % 2 == 1) ? W : K;
         3'd3: return (h % 64 == 0 || v % 64 == 0 || h == H_ACTIVE - 1 || v == V_ACTIVE - 1) ? W : K;
         3'd4: return (h >= bx && h < bx + BOX_SIZE && v >= by && v < by + BOX_SIZE) ? W : B;
         3'd5: return W;
         default: return K;
      endcase
   endfunction

   // Reference model: what leaves the block two edges after an input is sampled.
   int          m_frames;
   bit          m_synced;
   logic [2:0]  m_mode;
   logic [23:0] p_rgb, e_rgb;
   logic        p_hs, p_vs, p_bl, p_fs, e_hs, e_vs, e_bl, e_fs;

   always @(posedge clk) begin
      bit fs, eb;
      if (!rst_n) begin
         m_frames = 0; m_synced = 0; m_mode = 3'd0;
         p_rgb = '0; p_hs = 0; p_vs = 0; p_bl = 1; p_fs = 0;
         e_rgb = '0; e_hs = 0; e_vs = 0; e_bl = 1; e_fs = 0;
      end else begin
         e_rgb = p_rgb; e_hs = p_hs; e_vs = p_vs; e_bl = p_bl; e_fs = p_fs;
         fs = (hdata == 0) && (vdata == 0) && !blank;
         if (fs) begin
            m_mode = mode; m_frames++; m_synced = 1;
         end
         eb = blank || !m_synced;
         p_rgb = eb ? 24'd0 : model_rgb(m_mode, int'(hdata), int'(vdata), m_frames);
         p_hs = hsync; p_vs = vsync; p_bl = eb; p_fs = fs;
      end
      #2;
      check("rgb", {8'd0, red, green, blue}, {8'd0, e_rgb});
      check("hsync_o", 32'(hsync_o), 32'(e_hs));
      check("vsync_o", 32'(vsync_o), 32'(e_vs));
      check("blank_o", 32'(blank_o), 32'(e_bl));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("frame_cnt", 32'(frame_cnt), 32'(m_frames[15:0]));
   end

   task automatic pxs(input int h, input int v, input logic bl, input logic hs, input logic vs);
      @(negedge clk);
      hdata = WIDTH'(h); vdata = WIDTH'(v); blank = bl; hsync = hs; vsync = vs;
   endtask

   task automatic px(input int h, input int v, input logic bl);
      pxs(h, v, bl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // Drive one pixel then a blanked filler; check the pixel's colour when it emerges.
   task automatic px_lit(input string nm, input int h, input int v, input logic bl, input logic [23:0] exp);
      px(h, v, bl);
      px(H_ACTIVE + 8, v, 1'b1);
      @(posedge clk); #3;
      check(nm, {8'd0, red, green, blue}, {8'd0, exp});
   endtask

   initial begin
      // Reset released mid-line: output stays blanked until a (0,0) pixel.
      for (int i = 0; i < 3; i++) px(100 + i, 5, 1'b0);
      @(posedge clk); #3;
      check("rst_cnt", 32'(frame_cnt), 32'd0);
      check("rst_blank", 32'(blank_o), 32'd1);
      px(103, 5, 1'b0);
      rst_n = 1'b1;
      for (int i = 104; i < 110; i++) px(i, 5, 1'b0);
      @(posedge clk); #3;
      check("midline_blank", 32'(blank_o), 32'd1);
      check("midline_rgb", {8'd0, red, green, blue}, 32'd0);
      pxs(200, 5, 1'b1, 1'b1, 1'b0);
      pxs(201, 5, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #3;
      check("sync_hs", 32'(hsync_o), 32'd1);
      @(posedge clk); #3;
      check("sync_vs", 32'(vsync_o), 32'd1);

      // Colour bars.
      mode = 3'd0;
      px_lit("bar_00", 0, 0, 1'b0, W);
      check("bar_fs", 32'(frame_start), 32'd1);
      check("bar_cnt", 32'(frame_cnt), 32'd1);
      px_lit("bar_x0", 0, 1, 1'b0, W);
      px_lit("bar_x240", 240, 1, 1'b0, 24'hFFFF00);
      px_lit("bar_x1679", 1679, 1, 1'b0, 24'h0000FF);
      px_lit("bar_x1680", 1680, 1, 1'b0, K);
      px_lit("bar_blank", 240, 1, 1'b1, K);
      for (int x = 0; x < H_ACTIVE; x += 37) px(x, 2, 1'b0);

      // Mode change mid-frame is deferred to the next frame start.
      mode = 3'd2;
      px_lit("sw_hold", 240, 500, 1'b0, 24'hFFFF00);
      px_lit("chk_00", 0, 0, 1'b0, K);
      check("sw_fs", 32'(frame_start), 32'd1);
      check("sw_cnt", 32'(frame_cnt), 32'd2);
      px_lit("chk_32", 32, 0, 1'b0, W);
      check("sw_fs_once", 32'(frame_start), 32'd0);
      for (int x = 0; x < H_ACTIVE; x += 29) px(x, 40, 1'b0);

      // Grid, ramp, solids.
      mode = 3'd3;
      px_lit("grid_00", 0, 0, 1'b0, W);
      px_lit("grid_x64", 64, 3, 1'b0, W);
      px_lit("grid_x65", 65, 3, 1'b0, K);
      px_lit("grid_xend", 1919, 3, 1'b0, W);
      px_lit("grid_yend", 5, 1079, 1'b0, W);
      mode = 3'd1;
      px_lit("ramp_00", 0, 0, 1'b0, K);
      px_lit("ramp_x1919", 1919, 7, 1'b0, 24'hEFEFEF);
      px_lit("ramp_blank", 1919, 7, 1'b1, K);
      for (int x = 0; x < H_ACTIVE; x += 41) px(x, 8, 1'b0);
      for (int m = 5; m < 8; m++) begin
         mode = 3'(m);
         px_lit("solid", 0, 0, 1'b0, (m == 5) ? W : K);
         for (int x = 3; x < H_ACTIVE; x += 301) px(x, 9, 1'b0);
      end

      // Bouncing box from a fresh reset.
      @(negedge clk); rst_n = 1'b0;
      for (int i = 0; i < 3; i++) px(0, 0, 1'b1);
      rst_n = 1'b1;
      mode = 3'd4;
      for (int f = 1; f <= 466; f++) begin
         px(0, 0, 1'b0);
         if (f == 254) begin
            px_lit("box254_in", 1016, 1016, 1'b0, W);
            px_lit("box254_right", 1080, 1016, 1'b0, B);
            px_lit("box254_above", 1016, 1015, 1'b0, B);
         end else if (f == 464) begin
            px_lit("box464_in", 1856, 176, 1'b0, W);
            px_lit("box464_corner", 1919, 239, 1'b0, W);
            px_lit("box464_left", 1855, 176, 1'b0, B);
            px_lit("box464_below", 1856, 240, 1'b0, B);
         end else if (f == 465) begin
            px_lit("box465_in", 1852, 172, 1'b0, W);
            px_lit("box465_left", 1851, 172, 1'b0, B);
            px_lit("box465_right", 1916, 172, 1'b0, B);
         end else begin
            px($urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1), 1'b0);
         end
      end

      // Forced back-to-back frame starts across the 16-bit wrap.
      mode = 3'd5;
      for (int i = 0; i < 65535 - 466; i++) px(0, 0, 1'b0);
      @(posedge clk); #3;
      check("cnt_ffff", 32'(frame_cnt), 32'h0000FFFF);
      px(0, 0, 1'b0);
      @(posedge clk); #3;
      check("cnt_wrap", 32'(frame_cnt), 32'd0);
      check("wrap_fs", 32'(frame_start), 32'd1);
      px(0, 0, 1'b0);
      @(posedge clk); #3;
      check("cnt_after", 32'(frame_cnt), 32'd1);
      check("wrap_fs2", 32'(frame_start), 32'd1);
      for (int i = 0; i < 4; i++) px(H_ACTIVE + 8, 0, 1'b1);
      @(posedge clk); #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-source stage directly downstream of the VGA timing generator (hdata/vdata/hsync/vsync/blank producer).
- Turns timing coordinates into 24-bit RGB test patterns, including an animated bouncing box, through a fixed 2-cycle pipeline.
- Delays sync/blank by the same 2 cycles so outputs leave aligned to the DAC/encoder.
- Pattern mode is latched only at frame start, so a frame is never torn.

Parameters:
- WIDTH, 12, width of hdata/vdata.
- H_ACTIVE, 1920, active pixels per line.
- V_ACTIVE, 1080, active lines per frame.
- BOX_SIZE, 64, bouncing-box edge length in pixels.
- BOX_STEP, 4, box displacement per frame on each axis, in pixels.
- RAMP_SHIFT, 3, right shift applied to hdata for the grey ramp.
- CHK_SHIFT, 5, coordinate bit that selects checkerboard cells (32-pixel squares).

Ports:
- clk  in  1  pixel clock (148.5 MHz for 1080p60).
- rst_n  in  1  asynchronous active-low reset.
- hdata  in  WIDTH  horizontal pixel coordinate from the timing generator.
- vdata  in  WIDTH  vertical line coordinate from the timing generator.
- hsync  in  1  horizontal sync from the timing generator.
- vsync  in  1  vertical sync from the timing generator.
- blank  in  1  high outside the active area.
- mode  in  3  requested pattern; latched at frame start.
- red, green, blue  out  8 each  pixel colour.
- hsync_o, vsync_o, blank_o  out  1 each  sync/blank delayed 2 cycles.
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the outputs.
- frame_cnt  out  16  frames started since reset; wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release): red/green/blue=0, hsync_o=vsync_o=0, blank_o=1, frame_start=0, frame_cnt=0.
- Reset state, internal: mode_active=0, box_x=box_y=0, dx=dy=+, pipeline registers cleared.
- Reset mid-frame: outputs stay blanked until the next (0,0) pixel. Sync outputs resume passing through 2 cycles after release.
- Pipeline: inputs at cycle t drive outputs at the edge ending cycle t+1. Latency is exactly 2 for every output, including frame_start.
- Stage 1: registers the inputs and decodes the bar index by comparing hdata against elaboration-time thresholds H_ACTIVE*k/8, k=1..7. No divider.
- Stage 2: selects the colour and forces RGB=0 when the delayed blank is high.
- Frame-start event: input hdata==0, vdata==0 and blank==0. On the capturing edge:
  - mode_active<=mode;
  - frame_cnt increments;
  - box position updates.
  - The pixel (0,0) and the rest of that frame use the new mode and position.
- Box update, x axis (y axis identical with V_ACTIVE, box_y, dy). Let XM = H_ACTIVE-BOX_SIZE.
  - dx=+ and box_x+BOX_STEP >= XM: box_x<=XM, dx<=-.
  - dx=- and box_x <= BOX_STEP: box_x<=0, dx<=+.
  - Otherwise box_x +/- BOX_STEP.
  - The box animates every frame regardless of mode.
- Patterns (mode_active):
  - 0: 8 vertical bars, 1-bit RGB code per bar expanded to 0x00/0xFF. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - 1: grey ramp, R=G=B=(hdata>>RAMP_SHIFT)[7:0].
  - 2: checkerboard; white when hdata[CHK_SHIFT]^vdata[CHK_SHIFT]=1, else black.
  - 3: grid. White when any of the following holds, else black:
    - hdata[5:0]==0;
    - vdata[5:0]==0;
    - hdata==H_ACTIVE-1;
    - vdata==V_ACTIVE-1.
  - 4: bouncing box. White inside box_x<=hdata<box_x+BOX_SIZE and box_y<=vdata<box_y+BOX_SIZE; background blue (0,0,0xFF).
  - 5: solid white.
  - 6, 7: solid black.
- mode changes mid-frame have no visible effect until the next frame start.
- Coordinates outside the active range while blank=0 are not expected; colour is then don't-care but blank_o still follows blank.

Test Plan:
- Reset released mid-line -> RGB=0 and blank_o=1 until the first (0,0) pixel. hsync_o/vsync_o equal the inputs delayed 2 cycles.
- mode=0, one full frame -> pixel x=0 is FFFFFF, x=240 is FFFF00, x=1679 is 0000FF, x=1680 is 000000. Output appears 2 cycles after the input coordinate.
- mode switched 0->2 at line 500 -> rest of frame stays bars. Next frame pixel (32,0)=FFFFFF, (0,0)=000000; frame_start pulses once and frame_cnt increments by 1.
- mode=4 across 466 frames -> box_x is 1856 at frame 464 with dx negative, then 1852. box_y reaches 1016 at frame 254, then reverses. Pixel (box_x, box_y) white, (box_x+64, box_y) blue.
- mode=1 -> pixel x=1919 has R=G=B=0xEF (239). Any pixel with blank=1 outputs RGB=0.
- frame_cnt preloaded near wrap via 65536 forced frame starts -> wraps 0xFFFF->0x0000 with no glitch on frame_start.
